gnn_layer_engine: RTL and testbench

Parametrised, time-multiplexed successor to the fixed 4-4-2 DNN/GNN datapath. Computes a ReLU hidden layer (N_IN→N_HID) and exports it for neighbour aggregation, then computes a linear output layer (N_HID→N_OUT) over the aggregated vector. MACs are serialised over the reduction dimension, with valid/ready handshakes on every boundary. An optional bypass mode turns it into a plain two-layer DNN.

---
 rtl/gnn_pkg.sv | 37 +++
 rtl/gnn_mac_lane.sv | 35 +++
 rtl/gnn_layer_engine.sv | 203 ++++++++++++++++++++
 tb/tb_gnn_layer_engine.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gnn_pkg.sv
// Shared types, width helpers and default parameters for the GNN layer engine.
package gnn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    L1,
    RELU,
    L2,
    OUT
  } state_t;

  localparam int unsigned DEF_N_IN   = 4;
  localparam int unsigned DEF_N_HID  = 4;
  localparam int unsigned DEF_N_OUT  = 2;
  localparam int unsigned DEF_X_W    = 7;
  localparam int unsigned DEF_W_W    = 5;
  localparam int unsigned DEF_AGGR_W = 17;

  // Full-precision width of an n-term sum of a_w x b_w signed products.
  function automatic int unsigned hid_w(input int unsigned x_w, input int unsigned w_w,
                                        input int unsigned n_in);
    return x_w + w_w + int'($clog2(n_in));
  endfunction

  function automatic int unsigned out_w(input int unsigned aggr_w, input int unsigned w_w,
                                        input int unsigned n_hid);
    return aggr_w + w_w + int'($clog2(n_hid));
  endfunction

  // Reduction counter width, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > 1) ? int'($clog2(m)) : 1;
  endfunction

endpackage

// File: rtl/gnn_mac_lane.sv
// Signed multiply-accumulate lane with synchronous clear and enable.
module gnn_mac_lane #(
  parameter int unsigned A_W   = 7,
  parameter int unsigned B_W   = 5,
  parameter int unsigned ACC_W = 14
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [A_W-1:0]   a,
  input  logic signed [B_W-1:0]   b,
  output logic signed [ACC_W-1:0] acc_nxt_c
);

  localparam int unsigned P_W = A_W + B_W;

  logic signed [P_W-1:0]   prod;
  logic signed [ACC_W-1:0] acc_q;

  assign prod      = a * b;
  // Sum including the current term, so the owner can register the final value on the last step.
  assign acc_nxt_c = acc_q + ACC_W'(prod);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if (clr) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= acc_nxt_c;
    end
  end

endmodule

// File: rtl/gnn_layer_engine.sv
// Time-multiplexed two-layer GNN engine: ReLU hidden layer, external aggregation
// (or local bypass), then a linear output layer, with MACs serialised over the reduction index.
module gnn_layer_engine
  import gnn_pkg::*;
#(
  parameter int unsigned N_IN   = DEF_N_IN,
  parameter int unsigned N_HID  = DEF_N_HID,
  parameter int unsigned N_OUT  = DEF_N_OUT,
  parameter int unsigned X_W    = DEF_X_W,
  parameter int unsigned W_W    = DEF_W_W,
  parameter int unsigned AGGR_W = DEF_AGGR_W,
  localparam int unsigned HID_W = hid_w(X_W, W_W, N_IN),
  localparam int unsigned OUT_W = out_w(AGGR_W, W_W, N_HID)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N_IN*X_W-1:0]       x,
  input  logic [N_IN*N_HID*W_W-1:0] w1,
  input  logic [N_HID*N_OUT*W_W-1:0] w2,
  input  logic                      bypass_aggr,
  output logic                      relu_valid,
  output logic [N_HID*HID_W-1:0]    relu_data,
  input  logic                      aggr_valid,
  output logic                      aggr_ready,
  input  logic [N_HID*AGGR_W-1:0]   aggr_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N_OUT*OUT_W-1:0]    out_data
);

  localparam int unsigned K_W = cnt_w(N_IN, N_HID);

  state_t                   state_q, state_d;
  logic [K_W-1:0]           k_q;
  logic                     bypass_q;
  logic [N_IN*X_W-1:0]      x_q;
  logic signed [AGGR_W-1:0] a_q [N_HID];

  logic in_fire;
  logic clr1, en1, clr2, en2, ld_relu, ld_a, ld_out, k_clr;
  logic last1, last2;

  logic signed [X_W-1:0]    l1_a;
  logic signed [W_W-1:0]    l1_b [N_HID];
  logic signed [HID_W-1:0]  acc1_nxt [N_HID];
  logic signed [AGGR_W-1:0] l2_a;
  logic signed [W_W-1:0]    l2_b [N_OUT];
  logic signed [OUT_W-1:0]  acc2_nxt [N_OUT];
  logic [N_HID*HID_W-1:0]   relu_nxt;
  logic [N_OUT*OUT_W-1:0]   out_nxt;

  assign in_fire = in_valid && (state_q == IDLE);
  assign last1   = (k_q == K_W'(N_IN - 1));
  assign last2   = (k_q == K_W'(N_HID - 1));

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    clr1    = 1'b0;
    en1     = 1'b0;
    clr2    = 1'b0;
    en2     = 1'b0;
    ld_relu = 1'b0;
    ld_a    = 1'b0;
    ld_out  = 1'b0;
    k_clr   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = L1;
          clr1    = 1'b1;
          clr2    = 1'b1;
          k_clr   = 1'b1;
        end
      end
      L1: begin
        en1 = 1'b1;
        if (last1) begin
          state_d = RELU;
          ld_relu = 1'b1;
          k_clr   = 1'b1;
        end
      end
      RELU: begin
        if (bypass_q || aggr_valid) begin
          state_d = L2;
          ld_a    = 1'b1;
          clr2    = 1'b1;
          k_clr   = 1'b1;
        end
      end
      L2: begin
        en2 = 1'b1;
        if (last2) begin
          state_d = OUT;
          ld_out  = 1'b1;
          k_clr   = 1'b1;
        end
      end
      OUT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; strobes are registered from the next state so they track it exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      in_ready   <= 1'b1;
      relu_valid <= 1'b0;
      aggr_ready <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready   <= (state_d == IDLE);
      relu_valid <= (state_d == RELU);
      aggr_ready <= (state_d == RELU) && !bypass_q;
      out_valid  <= (state_d == OUT);
    end
  end

  // Operand selection for the current reduction step.
  always_comb begin
    l1_a = x_q[int'(k_q)*X_W +: X_W];
    l2_a = a_q[k_q];
    for (int h = 0; h < N_HID; h++) begin
      l1_b[h] = w1[(int'(k_q)*N_HID + h)*W_W +: W_W];
    end
    for (int o = 0; o < N_OUT; o++) begin
      l2_b[o] = w2[(int'(k_q)*N_OUT + o)*W_W +: W_W];
    end
  end

  for (genvar h = 0; h < N_HID; h++) begin : g_l1
    gnn_mac_lane #(.A_W(X_W), .B_W(W_W), .ACC_W(HID_W)) u_lane (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr1),
      .en        (en1),
      .a         (l1_a),
      .b         (l1_b[h]),
      .acc_nxt_c (acc1_nxt[h])
    );
  end

  for (genvar o = 0; o < N_OUT; o++) begin : g_l2
    gnn_mac_lane #(.A_W(AGGR_W), .B_W(W_W), .ACC_W(OUT_W)) u_lane (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr2),
      .en        (en2),
      .a         (l2_a),
      .b         (l2_b[o]),
      .acc_nxt_c (acc2_nxt[o])
    );
  end

  always_comb begin
    relu_nxt = '0;
    out_nxt  = '0;
    for (int h = 0; h < N_HID; h++) begin
      relu_nxt[h*HID_W +: HID_W] = acc1_nxt[h][HID_W-1] ? '0 : acc1_nxt[h];
    end
    for (int o = 0; o < N_OUT; o++) begin
      out_nxt[o*OUT_W +: OUT_W] = acc2_nxt[o];
    end
  end

  // Captured operands, reduction counter and held result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_q       <= '0;
      bypass_q  <= 1'b0;
      x_q       <= '0;
      relu_data <= '0;
      out_data  <= '0;
      for (int h = 0; h < N_HID; h++) a_q[h] <= '0;
    end else begin
      if (k_clr) begin
        k_q <= '0;
      end else if (en1 || en2) begin
        k_q <= k_q + K_W'(1);
      end
      if (in_fire) begin
        x_q      <= x;
        bypass_q <= bypass_aggr;
      end
      if (ld_relu) relu_data <= relu_nxt;
      if (ld_a) begin
        for (int h = 0; h < N_HID; h++) begin
          a_q[h] <= bypass_q ? AGGR_W'($signed(relu_data[h*HID_W +: HID_W]))
                             : aggr_data[h*AGGR_W +: AGGR_W];
        end
      end
      if (ld_out) out_data <= out_nxt;
    end
  end

endmodule

// File: tb/tb_gnn_layer_engine.sv
// Randomised and directed bench for gnn_layer_engine against a sum-of-products reference model.
module tb_gnn_layer_engine;

  localparam int N_IN   = 4;
  localparam int N_HID  = 4;
  localparam int N_OUT  = 2;
  localparam int X_W    = 7;
  localparam int W_W    = 5;
  localparam int AGGR_W = 17;
  localparam int HID_W  = X_W + W_W + $clog2(N_IN);
  localparam int OUT_W  = AGGR_W + W_W + $clog2(N_HID);

  logic                       clk;
  logic                       rst;
  logic                       in_valid;
  logic                       in_ready;
  logic [N_IN*X_W-1:0]        x;
  logic [N_IN*N_HID*W_W-1:0]  w1;
  logic [N_HID*N_OUT*W_W-1:0] w2;
  logic                       bypass_aggr;
  logic                       relu_valid;
  logic [N_HID*HID_W-1:0]     relu_data;
  logic                       aggr_valid;
  logic                       aggr_ready;
  logic [N_HID*AGGR_W-1:0]    aggr_data;
  logic                       out_valid;
  logic                       out_ready;
  logic [N_OUT*OUT_W-1:0]     out_data;

  gnn_layer_engine #(
    .N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT), .X_W(X_W), .W_W(W_W), .AGGR_W(AGGR_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .x(x), .w1(w1), .w2(w2),
    .bypass_aggr(bypass_aggr),
    .relu_valid(relu_valid), .relu_data(relu_data),
    .aggr_valid(aggr_valid), .aggr_ready(aggr_ready), .aggr_data(aggr_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     cx  [N_IN];
  int     cw1 [N_IN][N_HID];
  int     cw2 [N_HID][N_OUT];
  int     ca  [N_HID];
  longint exp_relu [N_HID];
  longint exp_out  [N_OUT];
  bit     exp_byp;
  bit     chk_en;
  int     n_cmp;
  int     n_bad;

  function automatic void chk(input string nm, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, req, $time);
    end
  endfunction

  function automatic longint relu_lane(input int h);
    return longint'($signed(relu_data[h*HID_W +: HID_W]));
  endfunction

  function automatic longint out_lane(input int o);
    return longint'($signed(out_data[o*OUT_W +: OUT_W]));
  endfunction

  // Reference: plain dot products, ReLU, then the second layer on the chosen vector.
  function automatic void model(input bit byp);
    longint s;
    for (int h = 0; h < N_HID; h++) begin
      s = 0;
      for (int i = 0; i < N_IN; i++) s += longint'(cx[i]) * longint'(cw1[i][h]);
      exp_relu[h] = (s > 0) ? s : 0;
    end
    for (int o = 0; o < N_OUT; o++) begin
      s = 0;
      for (int h = 0; h < N_HID; h++)
        s += (byp ? exp_relu[h] : longint'(ca[h])) * longint'(cw2[h][o]);
      exp_out[o] = s;
    end
    exp_byp = byp;
  endfunction

  task automatic set_all(input int xv, input int w1v, input int w2v, input int av);
    for (int i = 0; i < N_IN; i++) cx[i] = xv;
    for (int i = 0; i < N_IN; i++) for (int h = 0; h < N_HID; h++) cw1[i][h] = w1v;
    for (int h = 0; h < N_HID; h++) for (int o = 0; o < N_OUT; o++) cw2[h][o] = w2v;
    for (int h = 0; h < N_HID; h++) ca[h] = av;
  endtask

  task automatic set_rand();
    for (int i = 0; i < N_IN; i++) cx[i] = int'($urandom_range(0, 127)) - 64;
    for (int i = 0; i < N_IN; i++)
      for (int h = 0; h < N_HID; h++) cw1[i][h] = int'($urandom_range(0, 31)) - 16;
    for (int h = 0; h < N_HID; h++)
      for (int o = 0; o < N_OUT; o++) cw2[h][o] = int'($urandom_range(0, 31)) - 16;
    for (int h = 0; h < N_HID; h++) ca[h] = int'($urandom_range(0, 131071)) - 65536;
  endtask

  task automatic drive_static(input bit byp);
    for (int i = 0; i < N_IN; i++) x[i*X_W +: X_W] = X_W'(cx[i]);
    for (int i = 0; i < N_IN; i++)
      for (int h = 0; h < N_HID; h++) w1[(i*N_HID + h)*W_W +: W_W] = W_W'(cw1[i][h]);
    for (int h = 0; h < N_HID; h++)
      for (int o = 0; o < N_OUT; o++) w2[(h*N_OUT + o)*W_W +: W_W] = W_W'(cw2[h][o]);
    for (int h = 0; h < N_HID; h++) aggr_data[h*AGGR_W +: AGGR_W] = AGGR_W'(ca[h]);
    bypass_aggr = byp;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("in_ready_wait", longint'(in_ready), 1);
  endtask

  // One vector end-to-end with optional backpressure and busy-time pokes.
  task automatic run_vec(input bit byp, input int aggr_dly, input int out_dly, input bit poke,
                         input bit has_lit, input longint lit_relu, input longint lit_out);
    int n;
    int total;
    model(byp);
    wait_idle();
    drive_static(byp);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total = 0;
    chk("in_ready_drop", longint'(in_ready), 0);
    if (poke) begin
      in_valid   = 1'b1;
      aggr_valid = 1'b1;
      x = (N_IN*X_W)'($urandom);
      for (int h = 0; h < N_HID; h++) aggr_data[h*AGGR_W +: AGGR_W] = AGGR_W'($urandom);
    end
    n = 0;
    do begin
      @(posedge clk); #1; n++; total++;
      if (poke && n == 1) begin
        aggr_valid = 1'b0;
        drive_static(byp);
      end
    end while (!relu_valid && n < 50);
    chk("relu_latency", n, N_IN);
    in_valid = 1'b0;
    if (!byp) begin
      for (int d = 0; d < aggr_dly; d++) begin
        @(posedge clk); #1; total++;
        chk("relu_valid_hold", longint'(relu_valid), 1);
      end
      aggr_valid = 1'b1;
      @(posedge clk); #1;
      aggr_valid = 1'b0;
      total++;
    end
    if (out_dly == 0) out_ready = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1; n++; total++;
    end while (!out_valid && n < 50);
    chk("out_latency", n, byp ? N_HID + 1 : N_HID);
    if (byp) chk("bypass_total_latency", total, N_IN + 1 + N_HID);
    for (int d = 0; d < out_dly; d++) begin
      @(posedge clk); #1;
      chk("out_valid_hold", longint'(out_valid), 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("out_valid_pulse", longint'(out_valid), 0);
    chk("in_ready_after_out", longint'(in_ready), 1);
    for (int h = 0; h < N_HID; h++) chk("relu_data_held", relu_lane(h), exp_relu[h]);
    for (int o = 0; o < N_OUT; o++) chk("out_data_held", out_lane(o), exp_out[o]);
    if (has_lit) begin
      chk("relu_literal", relu_lane(0), lit_relu);
      chk("out_literal", out_lane(0), lit_out);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, longint'(in_ready), 1);
    chk({tag, "_relu_valid"}, longint'(relu_valid), 0);
    chk({tag, "_aggr_ready"}, longint'(aggr_ready), 0);
    chk({tag, "_out_valid"}, longint'(out_valid), 0);
    chk({tag, "_relu_data"}, longint'(relu_data != '0), 0);
    chk({tag, "_out_data"}, longint'(out_data != '0), 0);
  endtask

  // Per-cycle checks against the model whenever outputs carry meaning.
  always @(negedge clk) begin
    if (!rst && chk_en) begin
      if (relu_valid)
        for (int h = 0; h < N_HID; h++) chk("relu_data", relu_lane(h), exp_relu[h]);
      if (out_valid)
        for (int o = 0; o < N_OUT; o++) chk("out_data", out_lane(o), exp_out[o]);
      chk("aggr_ready", longint'(aggr_ready), longint'(relu_valid && !exp_byp));
      if (relu_valid || out_valid) chk("in_ready_busy", longint'(in_ready), 0);
    end
  end

  initial begin
    int n;
    n_cmp = 0; n_bad = 0; chk_en = 1'b0; exp_byp = 1'b0;
    rst = 1'b1; in_valid = 1'b0; aggr_valid = 1'b0; out_ready = 1'b0;
    x = '0; w1 = '0; w2 = '0; aggr_data = '0; bypass_aggr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;
    chk_en = 1'b1;

    set_all(1, 1, 3, 2);
    run_vec(1'b0, 0, 0, 1'b0, 1'b1, 4, 24);

    set_all(0, 1, 1, 0);
    cx[0] = -64;
    run_vec(1'b0, 1, 1, 1'b0, 1'b1, 0, 0);

    set_all(-64, -16, -16, -65536);
    run_vec(1'b0, 0, 0, 1'b0, 1'b1, 4096, 4194304);

    set_all(1, 1, 1, 0);
    run_vec(1'b1, 0, 0, 1'b0, 1'b1, 4, 16);

    set_rand();
    run_vec(1'b0, 10, 5, 1'b1, 1'b0, 0, 0);

    // Reset while layer 2 is running.
    set_rand();
    model(1'b0);
    wait_idle();
    drive_static(1'b0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!relu_valid && n < 50);
    chk("rst_test_relu_latency", n, N_IN);
    aggr_valid = 1'b1;
    @(posedge clk); #1;
    aggr_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk_reset_outputs("mid_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      chk("no_stale_out", longint'(out_valid), 0);
    end
    chk("in_ready_post_rst", longint'(in_ready), 1);

    set_all(1, 1, 3, 2);
    run_vec(1'b0, 0, 0, 1'b0, 1'b1, 4, 24);

    for (int t = 0; t < 24; t++) begin
      set_rand();
      run_vec(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              ($urandom_range(0, 3) == 0), 1'b0, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
